// File: rtl/l1_cache.sv
// rtl/l1_cache.sv - direct-mapped write-back write-allocate L1 cache, 8 lines x 32-bit blocks
// Optional hit/miss counters enabled by defining L1_CACHE_STATS_EN.
module l1_cache (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ready,
  output logic [7:0]  cpu_dout,
  output logic        mem_request,
  output logic        mem_we,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_din,
  input  logic        mem_ready,
  input  logic [31:0] mem_dout,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  typedef enum logic [2:0] {IDLE, COMPARE, WB_REQ, WB_WAIT, AL_REQ, AL_WAIT} state_t;

  state_t      state;
  logic [31:0] data_q [8];
  logic [2:0]  tag_q  [8];
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;

  logic        op_we;
  logic [7:0]  op_addr;
  logic [7:0]  op_din;

  logic [1:0]  off;
  logic [2:0]  idx;
  logic [2:0]  tg;
  logic        hit;
  logic [7:0]  rd_byte;

  assign off     = op_addr[1:0];
  assign idx     = op_addr[4:2];
  assign tg      = op_addr[7:5];
  assign hit     = valid_q[idx] && (tag_q[idx] == tg);
  assign rd_byte = data_q[idx][{off, 3'b000} +: 8];

  // Data and tag arrays carry no reset; valid bits alone decide their meaning.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == AL_WAIT && mem_ready) begin
        data_q[idx] <= mem_dout;
        tag_q[idx]  <= tg;
      end else if (state == COMPARE && hit && op_we) begin
        data_q[idx][{off, 3'b000} +: 8] <= op_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      cpu_ready   <= 1'b0;
      cpu_dout    <= '0;
      mem_request <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      op_we       <= 1'b0;
      op_addr     <= '0;
      op_din      <= '0;
    end else begin
      cpu_ready   <= 1'b0;
      mem_request <= 1'b0;
      mem_we      <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            op_we   <= cpu_we;
            op_addr <= cpu_addr;
            op_din  <= cpu_din;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            state     <= IDLE;
            if (op_we) begin
              dirty_q[idx] <= 1'b1;
              cpu_dout     <= op_din;
            end else begin
              cpu_dout <= rd_byte;
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            mem_request <= 1'b1;
            mem_we      <= 1'b1;
            mem_addr    <= {tag_q[idx], idx};
            mem_din     <= data_q[idx];
            state       <= WB_REQ;
          end else begin
            mem_request <= 1'b1;
            mem_addr    <= {tg, idx};
            state       <= AL_REQ;
          end
        end
        WB_REQ: state <= WB_WAIT;
        WB_WAIT: begin
          if (mem_ready) begin
            mem_request <= 1'b1;
            mem_addr    <= {tg, idx};
            state       <= AL_REQ;
          end
        end
        AL_REQ: state <= AL_WAIT;
        AL_WAIT: begin
          if (mem_ready) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            state        <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L1_CACHE_STATS_EN
  logic [15:0] hit_q;
  logic [15:0] miss_q;
  logic        refill;

  // refill marks the COMPARE that directly follows a fill, which is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
      refill <= 1'b0;
    end else begin
      refill <= (state == AL_WAIT) && mem_ready;
      if (state == COMPARE && !refill) begin
        if (hit) begin
          if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
        end else begin
          if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_cache.sv
// tb/tb_l1_cache.sv - self-checking bench for l1_cache against a flat byte-memory reference
// Optional counters checked when L1_CACHE_STATS_EN is defined.
module tb_l1_cache;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic        cpu_ready;
  logic [7:0]  cpu_dout;
  logic        mem_request;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_dout = '0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int errors = 0;
  int checks = 0;

  l1_cache dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_ready(cpu_ready), .cpu_dout(cpu_dout), .mem_request(mem_request),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ready(mem_ready),
    .mem_dout(mem_dout), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Main memory: registered ready and data one cycle after a request.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (mem_request) begin
      mem_ready <= 1'b1;
      mem_dout  <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_din;
    end
  end

  logic        tx_we [$];
  logic [5:0]  tx_addr [$];
  logic [31:0] tx_din [$];
  logic        prev_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_request) begin
      tx_we.push_back(mem_we);
      tx_addr.push_back(mem_addr);
      tx_din.push_back(mem_din);
      chk("req_not_back_to_back", {31'd0, prev_req}, 32'd0);
    end
    prev_req = mem_request;
  end

  // Reference: what the CPU should see is a flat 256-byte memory; the line
  // table only predicts which accesses hit and what gets evicted.
  logic [7:0] flat [256];
  logic [2:0] rt [8];
  logic       rv [8];
  logic       rd [8];
  int ref_hits = 0;
  int ref_misses = 0;

  task automatic ref_reset();
    for (int i = 0; i < 8; i++) begin rv[i] = 1'b0; rd[i] = 1'b0; rt[i] = '0; end
    for (int i = 0; i < 256; i++) flat[i] = mem[i / 4][(i % 4) * 8 +: 8];
    ref_hits = 0;
    ref_misses = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_ready"}, {31'd0, cpu_ready}, 32'd0);
    chk({tag, "_cpu_dout"}, {24'd0, cpu_dout}, 32'd0);
    chk({tag, "_mem_request"}, {31'd0, mem_request}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {26'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_din"}, mem_din, 32'd0);
    chk({tag, "_hit_count"}, {16'd0, hit_count}, 32'd0);
    chk({tag, "_miss_count"}, {16'd0, miss_count}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    ref_reset();
  endtask

  task automatic run_op(input logic we, input logic [7:0] addr, input logic [7:0] din, input bit hold);
    logic [2:0]  idx, tg;
    logic [7:0]  base, exp_dout, dout;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exp_wb, got;
    int          exp_lat, k, ntx;
    idx = addr[4:2];
    tg  = addr[7:5];
    exp_wb = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    if (rv[idx] && rt[idx] == tg) begin
      exp_lat = 1;
      ref_hits++;
    end else begin
      ref_misses++;
      exp_wb = rv[idx] && rd[idx];
      if (exp_wb) begin
        wb_addr = {rt[idx], idx};
        base = {rt[idx], idx, 2'b00};
        wb_data = {flat[base + 8'd3], flat[base + 8'd2], flat[base + 8'd1], flat[base]};
      end
      exp_lat = exp_wb ? 6 : 4;
      rt[idx] = tg;
      rv[idx] = 1'b1;
      rd[idx] = 1'b0;
    end
    if (we) begin
      flat[addr] = din;
      rd[idx] = 1'b1;
      exp_dout = din;
    end else begin
      exp_dout = flat[addr];
    end

    tx_we.delete(); tx_addr.delete(); tx_din.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
    @(posedge clk);
    #1;
    if (!hold) cpu_req = 1'b0;
    got = 1'b0; k = 0; dout = 'x;
    while (!got && k < 30) begin
      @(posedge clk);
      #1;
      k++;
      if (cpu_ready) begin got = 1'b1; dout = cpu_dout; end
    end
    cpu_req = 1'b0;
    chk("latency", k, exp_lat);
    chk("cpu_dout", {24'd0, dout}, {24'd0, exp_dout});
    ntx = (exp_lat == 1) ? 0 : (exp_wb ? 2 : 1);
    chk("tx_count", tx_addr.size(), ntx);
    if (ntx > 0 && tx_addr.size() == ntx) begin
      if (exp_wb) begin
        chk("wb_we", {31'd0, tx_we[0]}, 32'd1);
        chk("wb_addr", {26'd0, tx_addr[0]}, {26'd0, wb_addr});
        chk("wb_data", tx_din[0], wb_data);
      end
      chk("al_we", {31'd0, tx_we[ntx-1]}, 32'd0);
      chk("al_addr", {26'd0, tx_addr[ntx-1]}, {26'd0, tg, idx});
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef L1_CACHE_STATS_EN
    chk({tag, "_hits"}, {16'd0, hit_count}, ref_hits);
    chk({tag, "_misses"}, {16'd0, miss_count}, ref_misses);
`else
    chk({tag, "_hits"}, {16'd0, hit_count}, 32'd0);
    chk({tag, "_misses"}, {16'd0, miss_count}, 32'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int b = 0; b < 64; b++)
      mem[b] = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    reset = 1'b0;
    ref_reset();

    run_op(1'b0, 8'h05, 8'h00, 1'b0);
    run_op(1'b0, 8'h05, 8'h00, 1'b0);
    run_op(1'b1, 8'h06, 8'hAA, 1'b0);
    run_op(1'b0, 8'h26, 8'h00, 1'b0);
    run_op(1'b0, 8'h06, 8'h00, 1'b0);
    check_stats("directed");

    // Reset while the allocate read is outstanding.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h45;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midop");
    @(negedge clk);
    reset = 1'b0;
    ref_reset();
    cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (cpu_ready) cnt++; end
    chk("midop_no_ready", cnt, 0);
    run_op(1'b0, 8'h45, 8'h00, 1'b0);

    // cpu_req held high through a miss: one completion only.
    run_op(1'b0, 8'h80, 8'h00, 1'b1);
    cnt = 0;
    repeat (8) begin @(posedge clk); #1; if (cpu_ready) cnt++; end
    chk("hold_no_extra_ready", cnt, 0);

    apply_reset();
    run_op(1'b0, 8'h10, 8'h00, 1'b0);
    run_op(1'b0, 8'h11, 8'h00, 1'b0);
    run_op(1'b1, 8'h12, 8'h5C, 1'b0);
    run_op(1'b0, 8'h30, 8'h00, 1'b0);
    check_stats("stats_seq");

    for (int i = 0; i < 150; i++)
      run_op(1'($urandom_range(0, 1)), {3'($urandom_range(0, 2)), 5'($urandom)}, 8'($urandom), 1'b0);
    check_stats("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
